// File: rtl/sync_fifo_pkg.sv
// Shared defaults and parameter legality check for the synchronous FIFO.
package sync_fifo_pkg;

   localparam int DefDataSize = 8;
   localparam int DefAddrSize = 3;

   function automatic bit thresholds_ok(input int addr_size, input int af_th, input int ae_th);
      int depth;
      depth = 1 << addr_size;
      return (af_th >= 1) && (af_th <= depth) && (ae_th >= 0) && (ae_th <= depth - 1);
   endfunction

endpackage

// File: rtl/sync_fifo_props.sv
// Concurrent-assertion checker for sync_fifo, attached to every instance by bind.
module sync_fifo_props #(
   parameter int AddrSize = 3
) (
   input logic                Clk,
   input logic                Reset,
   input logic                Clear,
   input logic                Pop,
   input logic                full,
   input logic                empty,
   input logic                DataValid,
   input logic [AddrSize:0]   Count
);

   typedef logic [AddrSize:0] cnt_t;
   localparam cnt_t DepthCnt = cnt_t'(2**AddrSize);

   a_empty_in_reset: assert property (@(posedge Clk) Reset |-> empty)
      else $error("a_empty_in_reset: empty not asserted during Reset");

   a_not_full_and_empty: assert property (@(posedge Clk) disable iff (Reset) !(full && empty))
      else $error("a_not_full_and_empty: full and empty asserted together");

   a_count_range: assert property (@(posedge Clk) disable iff (Reset) Count <= DepthCnt)
      else $error("a_count_range: Count %0d exceeds depth", Count);

   a_valid_after_pop: assert property (@(posedge Clk) disable iff (Reset)
      DataValid |-> $past(Pop && !empty && !Clear))
      else $error("a_valid_after_pop: DataValid without an accepted pop in the previous cycle");

endmodule

bind sync_fifo sync_fifo_props #(.AddrSize(AddrSize)) u_props (
   .Clk       (Clk),
   .Reset     (Reset),
   .Clear     (Clear),
   .Pop       (Pop),
   .full      (full),
   .empty     (empty),
   .DataValid (DataValid),
   .Count     (Count)
);

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count, threshold flags
// and sticky overflow/underflow error flags.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DataSize      = DefDataSize,
   parameter int AddrSize      = DefAddrSize,
   parameter int AlmostFullTh  = (2**AddrSize) - 2,
   parameter int AlmostEmptyTh = 1
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                Clear,
   input  logic                Push,
   input  logic                Pop,
   input  logic [DataSize-1:0] DataIn,
   output logic [DataSize-1:0] DataOut,
   output logic                DataValid,
   output logic                full,
   output logic                empty,
   output logic                AlmostFull,
   output logic                AlmostEmpty,
   output logic [AddrSize:0]   Count,
   output logic                Overflow,
   output logic                Underflow
);

   localparam int Depth = 2**AddrSize;
   typedef logic [AddrSize:0] ptr_t;
   localparam ptr_t DepthCnt = ptr_t'(Depth);
   localparam ptr_t AfTh     = ptr_t'(AlmostFullTh);
   localparam ptr_t AeTh     = ptr_t'(AlmostEmptyTh);

   if (!thresholds_ok(AddrSize, AlmostFullTh, AlmostEmptyTh)) begin : g_bad_threshold
      $error("sync_fifo: illegal AlmostFullTh=%0d / AlmostEmptyTh=%0d for Depth=%0d",
             AlmostFullTh, AlmostEmptyTh, Depth);
   end

   logic [DataSize-1:0] mem_q [Depth];
   ptr_t                wr_ptr_q, wr_ptr_d;
   ptr_t                rd_ptr_q, rd_ptr_d;
   ptr_t                count_q, count_d;
   logic [DataSize-1:0] data_out_q, data_out_d;
   logic                data_valid_q, data_valid_d;
   logic                overflow_q, overflow_d;
   logic                underflow_q, underflow_d;
   logic                push_ok, pop_ok;

   // Flags come only from the registered count, so Push/Pop never reach them combinationally.
   assign full        = (count_q == DepthCnt);
   assign empty       = (count_q == '0);
   assign AlmostFull  = (count_q >= AfTh);
   assign AlmostEmpty = (count_q <= AeTh);

   assign push_ok = Push && !full && !Clear;
   assign pop_ok  = Pop && !empty && !Clear;

   always_comb begin
      // NOTE: every _d gets a default first so no path through this block infers a latch.
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      overflow_d   = overflow_q;
      underflow_d  = underflow_q;
      if (Clear) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            data_out_d   = mem_q[rd_ptr_q[AddrSize-1:0]];
            data_valid_d = 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
         if (Push && full)  overflow_d  = 1'b1;
         if (Pop && empty)  underflow_d = 1'b1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   // NOTE: storage has no reset; resetting the pointers and count is enough to discard its contents.
   always_ff @(posedge Clk) begin
      if (push_ok) mem_q[wr_ptr_q[AddrSize-1:0]] <= DataIn;
   end

   assign DataOut   = data_out_q;
   assign DataValid = data_valid_q;
   assign Count     = count_q;
   assign Overflow  = overflow_q;
   assign Underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue scoreboard plus a table of threshold vectors.
module tb_sync_fifo;

   localparam int Depth = 8;

   logic       Clk = 1'b0;
   logic       Reset, Clear, Push, Pop;
   logic [7:0] DataIn, DataOut;
   logic       DataValid, full, empty, AlmostFull, AlmostEmpty, Overflow, Underflow;
   logic [3:0] Count;

   sync_fifo #(
      .DataSize      (8),
      .AddrSize      (3),
      .AlmostFullTh  (6),
      .AlmostEmptyTh (1)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Clear       (Clear),
      .Push        (Push),
      .Pop         (Pop),
      .DataIn      (DataIn),
      .DataOut     (DataOut),
      .DataValid   (DataValid),
      .full        (full),
      .empty       (empty),
      .AlmostFull  (AlmostFull),
      .AlmostEmpty (AlmostEmpty),
      .Count       (Count),
      .Overflow    (Overflow),
      .Underflow   (Underflow)
   );

   always #5 Clk = ~Clk;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] sb [$];
   bit         m_ovf, m_unf;
   logic [7:0] m_dout;

   typedef struct {
      bit         push;
      bit         pop;
      bit         clr;
      logic [7:0] din;
      int         count;
      bit         af;
      bit         ae;
      bit         emp;
      bit         full;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [9:0] dut_status();
      return {Count, full, empty, AlmostFull, AlmostEmpty, Overflow, Underflow};
   endfunction

   function automatic logic [9:0] model_status();
      int n;
      n = sb.size();
      return {4'(n), n == Depth, n == 0, n >= 6, n <= 1, m_ovf, m_unf};
   endfunction

   task automatic model_reset();
      sb.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_dout = 8'h00;
   endtask

   task automatic check_reset(input string tag);
      check({tag, " status"}, dut_status(), {4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
      check({tag, " dout"}, DataOut, 8'h00);
      check({tag, " valid"}, DataValid, 1'b0);
   endtask

   // Drives one cycle, records expected words at drive time, compares after the edge.
   task automatic step(input bit push, input bit pop, input bit clr, input logic [7:0] din,
                       input string tag);
      bit push_ok, pop_ok;
      Push   = push;
      Pop    = pop;
      Clear  = clr;
      DataIn = din;
      pop_ok  = pop && !clr && sb.size() != 0;
      push_ok = push && !clr && sb.size() != Depth;
      if (clr) begin
         sb.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (pop && sb.size() == 0)     m_unf = 1'b1;
         if (push && sb.size() == Depth) m_ovf = 1'b1;
      end
      if (push_ok) sb.push_back(din);
      @(posedge Clk);
      #1;
      if (pop_ok) m_dout = sb.pop_front();
      check({tag, " valid"}, DataValid, pop_ok);
      check({tag, " dout"}, DataOut, m_dout);
      check({tag, " status"}, dut_status(), model_status());
      Push  = 1'b0;
      Pop   = 1'b0;
      Clear = 1'b0;
   endtask

   initial begin
      vec_t tbl [14];
      tbl = '{
         '{1'b1, 1'b0, 1'b0, 8'h31, 1, 1'b0, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b0, 1'b0, 8'h32, 2, 1'b0, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b0, 1'b0, 8'h33, 3, 1'b0, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b0, 1'b0, 8'h34, 4, 1'b0, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b0, 1'b0, 8'h35, 5, 1'b0, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b0, 1'b0, 8'h36, 6, 1'b1, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b0, 1'b0, 8'h37, 7, 1'b1, 1'b0, 1'b0, 1'b0},
         '{1'b0, 1'b1, 1'b0, 8'h00, 6, 1'b1, 1'b0, 1'b0, 1'b0},
         '{1'b0, 1'b1, 1'b0, 8'h00, 5, 1'b0, 1'b0, 1'b0, 1'b0},
         '{1'b0, 1'b1, 1'b0, 8'h00, 4, 1'b0, 1'b0, 1'b0, 1'b0},
         '{1'b0, 1'b1, 1'b0, 8'h00, 3, 1'b0, 1'b0, 1'b0, 1'b0},
         '{1'b0, 1'b1, 1'b0, 8'h00, 2, 1'b0, 1'b0, 1'b0, 1'b0},
         '{1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b1, 1'b0, 1'b0},
         '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b0}
      };

      Reset  = 1'b1;
      Clear  = 1'b0;
      Push   = 1'b0;
      Pop    = 1'b0;
      DataIn = 8'h00;
      model_reset();
      #1;
      check_reset("reset_initial");
      repeat (2) @(posedge Clk);
      #1;
      check_reset("reset_held");
      Reset = 1'b0;

      // Underflow from empty, then a push accepted alongside a rejected pop.
      step(1'b0, 1'b1, 1'b0, 8'h00, "pop_empty");
      step(1'b1, 1'b1, 1'b0, 8'h5A, "push_pop_empty");
      step(1'b0, 1'b1, 1'b0, 8'h00, "pop_5a");
      step(1'b0, 0, 1'b1, 8'h00, "clr_a");

      // Fill, overflow, drain in order.
      for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0, 8'(i), $sformatf("fill%0d", i));
      step(1'b1, 1'b0, 1'b0, 8'h09, "push_full");
      for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, 8'h00, $sformatf("drain%0d", i));
      step(1'b0, 1'b0, 1'b1, 8'h00, "clr_b");

      // Simultaneous push/pop at Count=3 long enough for both pointers to wrap.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'hA0 + 8'(i), $sformatf("pre%0d", i));
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 8'hB0 + 8'(i), $sformatf("pp%0d", i));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'h00, $sformatf("post%0d", i));
      step(1'b0, 1'b0, 1'b1, 8'h00, "clr_c");

      // Threshold table.
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].din, $sformatf("tbl%0d", i));
         check($sformatf("tbl%0d count", i), Count, 4'(tbl[i].count));
         check($sformatf("tbl%0d flags", i), {AlmostFull, AlmostEmpty, empty, full},
               {tbl[i].af, tbl[i].ae, tbl[i].emp, tbl[i].full});
      end
      step(1'b0, 1'b0, 1'b1, 8'h00, "clr_d");

      // Push+pop while full drops the push only; then Clear beats a push at Count=7.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'hC0 + 8'(i), $sformatf("cfill%0d", i));
      step(1'b1, 1'b0, 1'b0, 8'hCF, "cpush_full");
      step(1'b1, 1'b1, 1'b0, 8'hCE, "cpushpop_full");
      check("count7", Count, 4'd7);
      step(1'b1, 1'b0, 1'b1, 8'hEE, "clear_push");
      check("clear_push count", Count, 4'd0);
      check("clear_push flags", {empty, Overflow}, 2'b10);
      step(1'b0, 1'b1, 1'b0, 8'h00, "pop_after_clear");
      step(1'b0, 1'b0, 1'b1, 8'h00, "clr_e");

      // Asynchronous reset between edges at Count=4.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'hD0 + 8'(i), $sformatf("rfill%0d", i));
      step(1'b0, 1'b1, 1'b0, 8'h00, "rpop");
      step(1'b1, 1'b0, 1'b0, 8'hD4, "rpush");
      check("pre_reset count", Count, 4'd4);
      #3;
      Reset = 1'b1;
      model_reset();
      #1;
      check_reset("async_reset");
      #2;
      Reset = 1'b0;
      step(1'b0, 1'b1, 1'b0, 8'h00, "pop_after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DataSize, default 8, meaning word width in bits.
REQ-002 SHALL have parameter AddrSize, default 3, meaning address bits; Depth = 2**AddrSize entries.
REQ-003 SHALL have parameter AlmostFullTh, default Depth-2, meaning AlmostFull asserts at Count >= value; legal range 1..Depth.
REQ-004 SHALL have parameter AlmostEmptyTh, default 1, meaning AlmostEmpty asserts at Count <= value; legal range 0..Depth-1.
REQ-005 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port Reset, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port Clear, input, 1, synchronous flush.
REQ-008 SHALL have port Push, input, 1, write request.
REQ-009 SHALL have port Pop, input, 1, read request.
REQ-010 SHALL have port DataIn, input, DataSize, write data.
REQ-011 SHALL have port DataOut, output, DataSize, registered read data.
REQ-012 SHALL have port DataValid, output, 1, one-cycle pulse qualifying DataOut.
REQ-013 SHALL have ports full, empty, AlmostFull, AlmostEmpty, output, 1 each, status flags.
REQ-014 SHALL have port Count, output, AddrSize+1, current occupancy 0..Depth.
REQ-015 SHALL have ports Overflow and Underflow, output, 1 each, sticky error flags.

Function
REQ-016 A push SHALL be accepted iff Push=1 and full=0; DataIn is written at the write pointer and the write pointer advances by one.
REQ-017 A pop SHALL be accepted iff Pop=1 and empty=0; the read pointer advances by one.
REQ-018 On an accepted pop, DataOut SHALL present the popped word and DataValid SHALL be 1 in the cycle after the pop (1-cycle latency). Otherwise DataOut holds and DataValid is 0.
REQ-019 Pointers SHALL be AddrSize+1 bits and wrap modulo 2*Depth; the MSB difference distinguishes full from empty.
REQ-020 Count SHALL update as follows: +1 on push-only, -1 on pop-only, unchanged on both-accepted or neither.
REQ-021 Flags SHALL be: full = (Count==Depth); empty = (Count==0); AlmostFull = (Count>=AlmostFullTh); AlmostEmpty = (Count<=AlmostEmptyTh). All flags derive only from registered state, with no combinational path from Push or Pop.
REQ-022 Push while full SHALL be rejected with memory and pointers unchanged, even when Pop=1 in the same cycle (the pop is still accepted); Overflow is set.
REQ-023 Pop while empty SHALL be rejected, DataValid stays 0, and Underflow is set; a concurrent Push is still accepted.
REQ-024 Overflow and Underflow SHALL stay 1 until Clear or Reset.
REQ-025 Clear SHALL have priority over Push and Pop. Within one cycle it zeroes the pointers and Count, clears Overflow, Underflow and DataValid, and holds DataOut.
REQ-026 Illegal threshold parameters SHALL cause an elaboration-time error.

Reset
REQ-027 Reset SHALL act immediately, independent of Clk.
REQ-028 During Reset the outputs SHALL be: empty=1, AlmostEmpty=1, full=0, AlmostFull=0, Count=0, DataOut=0, DataValid=0, Overflow=0, Underflow=0.
REQ-029 Storage memory SHALL NOT be reset.
REQ-030 Reset asserted mid-operation SHALL discard all stored words; the first pop after release with no intervening push is an underflow.

Structure
REQ-031 Package sync_fifo_pkg SHALL hold the default DataSize and AddrSize constants and the threshold legality check function.
REQ-032 Checker sub-module sync_fifo_props SHALL be attached by bind. It SHALL hold concurrent assertions for:
- empty during Reset;
- full and empty never asserted together;
- Count within 0..Depth;
- DataValid only one cycle after an accepted pop.
REQ-033 Each assertion failure SHALL print a message identifying the assertion.

Verification (DataSize=8, AddrSize=3, Depth=8, AlmostFullTh=6, AlmostEmptyTh=1)
REQ-034 Push 0x01..0x08, then push 0x09 -> full=1, Count=8, Overflow=1; popping 8 times returns 0x01..0x08 in order, each with DataValid.
REQ-035 Pop from empty after Reset -> Underflow=1, DataValid=0, Count=0.
REQ-036 Push with Pop held for 20 cycles from Count=3 -> Count stays 3; pointers wrap past 15 -> 0 with data order preserved.
REQ-037 Fill to Count=5, then to 6 -> AlmostFull rises at 6; drain to 1 -> AlmostEmpty rises at Count=1, empty rises at Count=0.
REQ-038 Clear asserted at Count=7 with Push=1 -> next cycle Count=0, empty=1, Overflow=0, and the pushed word is discarded.
REQ-039 Reset asserted between Clk edges at Count=4 -> outputs take their reset values immediately, without waiting for a Clk edge.
